// File: rtl/axi_stream_to_galapagos_bridge.sv
// Serializes each FINN AXI-Stream word into one Galapagos packet of BEATS beats, LSB first,
// tagged with this kernel's id and a destination id captured when the word is accepted.
module axi_stream_to_galapagos_bridge #(
   parameter int GALAPAGOS_DATA_WIDTH    = 32,
   parameter int AXI_STREAM_DATA_WIDTH   = 48,
   parameter int GALAPAGOS_MAX_TRANSFERS = 16
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic [31:0]                       i_core_TID,
   input  logic [7:0]                        i_dest_TID,
   input  logic                              i_axis_TVALID,
   output logic                              o_axis_TREADY,
   input  logic [AXI_STREAM_DATA_WIDTH-1:0]  i_axis_TDATA,
   output logic                              o_gp_TVALID,
   input  logic                              i_gp_TREADY,
   output logic [GALAPAGOS_DATA_WIDTH-1:0]   o_gp_TDATA,
   output logic [GALAPAGOS_DATA_WIDTH/8-1:0] o_gp_TKEEP,
   output logic [7:0]                        o_gp_TDEST,
   output logic [7:0]                        o_gp_TID,
   output logic                              o_gp_TLAST
);

   localparam int GDW        = GALAPAGOS_DATA_WIDTH;
   localparam int KW         = GDW / 8;
   localparam int BEATS      = (AXI_STREAM_DATA_WIDTH + GDW - 1) / GDW;
   localparam int SHIFT_W    = BEATS * GDW;
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LAST_BYTES = ((AXI_STREAM_DATA_WIDTH / 8 - 1) % KW) + 1;
   localparam logic [KW-1:0] FULL_KEEP = '1;
   localparam logic [KW-1:0] LAST_KEEP = FULL_KEEP >> (KW - LAST_BYTES);

   if (BEATS > GALAPAGOS_MAX_TRANSFERS) begin : g_beats_too_large
      $error("axi_stream_to_galapagos_bridge: BEATS exceeds GALAPAGOS_MAX_TRANSFERS");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state;
   logic [SHIFT_W-1:0] shift_q;
   logic [CNT_W-1:0]   cnt;
   logic               axis_fire;
   logic               gp_fire;
   logic               last_next;
   logic               unused_core_tid;

   assign unused_core_tid = ^i_core_TID[31:8];

   // Ready is combinational so a new word can be taken on the last-beat handshake,
   // giving back-to-back packets with no bubble.
   assign o_axis_TREADY = !i_reset && (state == IDLE || (o_gp_TVALID && i_gp_TREADY && o_gp_TLAST));
   assign axis_fire     = i_axis_TVALID && o_axis_TREADY;
   assign gp_fire       = o_gp_TVALID && i_gp_TREADY;
   assign last_next     = (cnt == CNT_W'(BEATS - 2));
   assign o_gp_TDATA    = shift_q[GDW-1:0];

   // NOTE: every state element uses <= so all updates see pre-edge values of each other.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         shift_q     <= '0;
         cnt         <= '0;
         o_gp_TVALID <= 1'b0;
         o_gp_TLAST  <= 1'b0;
         o_gp_TKEEP  <= '0;
         o_gp_TDEST  <= '0;
         o_gp_TID    <= '0;
      end else if (axis_fire) begin
         state       <= SEND;
         shift_q     <= SHIFT_W'(i_axis_TDATA);
         cnt         <= '0;
         o_gp_TVALID <= 1'b1;
         o_gp_TLAST  <= (BEATS == 1);
         o_gp_TKEEP  <= (BEATS == 1) ? LAST_KEEP : FULL_KEEP;
         o_gp_TDEST  <= i_dest_TID;
         o_gp_TID    <= i_core_TID[7:0];
      end else if (gp_fire) begin
         if (o_gp_TLAST) begin
            state       <= IDLE;
            o_gp_TVALID <= 1'b0;
            o_gp_TLAST  <= 1'b0;
         end else begin
            shift_q    <= shift_q >> GDW;
            cnt        <= cnt + CNT_W'(1);
            o_gp_TLAST <= last_next;
            o_gp_TKEEP <= last_next ? LAST_KEEP : FULL_KEEP;
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_to_galapagos_bridge.sv
// Directed bench: a 32/48-bit bridge (two-beat packets) and a 64/64-bit bridge (single beat).
module tb_axi_stream_to_galapagos_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] core_tid;
   logic [7:0]  dest_tid;

   logic        a_axis_valid, a_axis_ready, a_gp_valid, a_gp_ready, a_gp_last;
   logic [47:0] a_axis_data;
   logic [31:0] a_gp_data;
   logic [3:0]  a_gp_keep;
   logic [7:0]  a_gp_dest, a_gp_tid;

   logic        b_axis_valid, b_axis_ready, b_gp_valid, b_gp_ready, b_gp_last;
   logic [63:0] b_axis_data, b_gp_data;
   logic [7:0]  b_gp_keep, b_gp_dest, b_gp_tid;

   int n_checks = 0;
   int n_fail   = 0;
   int a_beats  = 0;
   int beats_start;

   always #5 clk = ~clk;

   always @(posedge clk) if (a_gp_valid && a_gp_ready) a_beats <= a_beats + 1;

   axi_stream_to_galapagos_bridge dut_a (
      .i_clk(clk), .i_reset(rst), .i_core_TID(core_tid), .i_dest_TID(dest_tid),
      .i_axis_TVALID(a_axis_valid), .o_axis_TREADY(a_axis_ready), .i_axis_TDATA(a_axis_data),
      .o_gp_TVALID(a_gp_valid), .i_gp_TREADY(a_gp_ready), .o_gp_TDATA(a_gp_data),
      .o_gp_TKEEP(a_gp_keep), .o_gp_TDEST(a_gp_dest), .o_gp_TID(a_gp_tid), .o_gp_TLAST(a_gp_last)
   );

   axi_stream_to_galapagos_bridge #(
      .GALAPAGOS_DATA_WIDTH(64), .AXI_STREAM_DATA_WIDTH(64), .GALAPAGOS_MAX_TRANSFERS(16)
   ) dut_b (
      .i_clk(clk), .i_reset(rst), .i_core_TID(core_tid), .i_dest_TID(dest_tid),
      .i_axis_TVALID(b_axis_valid), .o_axis_TREADY(b_axis_ready), .i_axis_TDATA(b_axis_data),
      .o_gp_TVALID(b_gp_valid), .i_gp_TREADY(b_gp_ready), .o_gp_TDATA(b_gp_data),
      .o_gp_TKEEP(b_gp_keep), .o_gp_TDEST(b_gp_dest), .o_gp_TID(b_gp_tid), .o_gp_TLAST(b_gp_last)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks the whole beat presented by instance A.
   task automatic check_a(input string tag, input logic [31:0] data, input logic [3:0] keep,
                          input logic last, input logic [7:0] dest, input logic [7:0] tid);
      check({tag, ".valid"}, 64'(a_gp_valid), 64'd1);
      check({tag, ".data"},  64'(a_gp_data),  64'(data));
      check({tag, ".keep"},  64'(a_gp_keep),  64'(keep));
      check({tag, ".last"},  64'(a_gp_last),  64'(last));
      check({tag, ".dest"},  64'(a_gp_dest),  64'(dest));
      check({tag, ".tid"},   64'(a_gp_tid),   64'(tid));
   endtask

   initial begin
      rst = 1'b1; core_tid = 32'h0000_0001; dest_tid = 8'd4;
      a_axis_valid = 1'b0; a_axis_data = '0; a_gp_ready = 1'b1;
      b_axis_valid = 1'b0; b_axis_data = '0; b_gp_ready = 1'b1;
      tick(); tick();

      // Reset state
      check("rst.valid", 64'(a_gp_valid), 64'd0);
      check("rst.last",  64'(a_gp_last),  64'd0);
      check("rst.data",  64'(a_gp_data),  64'd0);
      check("rst.keep",  64'(a_gp_keep),  64'd0);
      check("rst.dest",  64'(a_gp_dest),  64'd0);
      check("rst.tid",   64'(a_gp_tid),   64'd0);
      check("rst.ready", 64'(a_axis_ready), 64'd0);
      check("rst.b_valid", 64'(b_gp_valid), 64'd0);
      rst = 1'b0;
      #1 check("idle.ready", 64'(a_axis_ready), 64'd1);

      // Single packet, router always ready, one-cycle latency
      a_axis_valid = 1'b1; a_axis_data = 48'h1234_5678_9ABC;
      tick();
      check_a("p1.b0", 32'h5678_9ABC, 4'b1111, 1'b0, 8'd4, 8'd1);
      a_axis_valid = 1'b0;
      #1 check("p1.b0.ready", 64'(a_axis_ready), 64'd0);
      tick();
      check_a("p1.b1", 32'h0000_1234, 4'b0011, 1'b1, 8'd4, 8'd1);
      check("p1.b1.ready", 64'(a_axis_ready), 64'd1);
      tick();
      check("p1.end.valid", 64'(a_gp_valid), 64'd0);

      // Two words back to back: four beats with no gap
      a_axis_valid = 1'b1; a_axis_data = 48'h1111_2222_3333;
      tick();
      check_a("bb.w1b0", 32'h2222_3333, 4'b1111, 1'b0, 8'd4, 8'd1);
      a_axis_data = 48'hAAAA_BBBB_CCCC;
      #1 check("bb.w1b0.ready", 64'(a_axis_ready), 64'd0);
      tick();
      check_a("bb.w1b1", 32'h0000_1111, 4'b0011, 1'b1, 8'd4, 8'd1);
      check("bb.w1b1.ready", 64'(a_axis_ready), 64'd1);
      tick();
      check_a("bb.w2b0", 32'hBBBB_CCCC, 4'b1111, 1'b0, 8'd4, 8'd1);
      a_axis_valid = 1'b0;
      tick();
      check_a("bb.w2b1", 32'h0000_AAAA, 4'b0011, 1'b1, 8'd4, 8'd1);
      check("bb.w2b1.ready", 64'(a_axis_ready), 64'd1);
      tick();
      check("bb.end.valid", 64'(a_gp_valid), 64'd0);

      // Router ready pattern 1-0-0-1 across the packet
      a_axis_valid = 1'b1; a_axis_data = 48'h1234_5678_9ABC;
      tick();
      a_axis_valid = 1'b0;
      beats_start = a_beats;
      check_a("st.b0", 32'h5678_9ABC, 4'b1111, 1'b0, 8'd4, 8'd1);
      tick();
      check_a("st.b1", 32'h0000_1234, 4'b0011, 1'b1, 8'd4, 8'd1);
      a_gp_ready = 1'b0;
      #1 check("st.stall.ready", 64'(a_axis_ready), 64'd0);
      tick();
      check_a("st.hold1", 32'h0000_1234, 4'b0011, 1'b1, 8'd4, 8'd1);
      tick();
      check_a("st.hold2", 32'h0000_1234, 4'b0011, 1'b1, 8'd4, 8'd1);
      a_gp_ready = 1'b1;
      tick();
      check("st.end.valid", 64'(a_gp_valid), 64'd0);
      check("st.beats", 64'(a_beats - beats_start), 64'd2);

      // Single-beat configuration on instance B
      b_axis_valid = 1'b1; b_axis_data = 64'hABCD_EFAB_ABCD_EFAB;
      tick();
      b_axis_valid = 1'b0;
      check("b.valid", 64'(b_gp_valid), 64'd1);
      check("b.data",  b_gp_data, 64'hABCD_EFAB_ABCD_EFAB);
      check("b.keep",  64'(b_gp_keep), 64'hFF);
      check("b.last",  64'(b_gp_last), 64'd1);
      check("b.dest",  64'(b_gp_dest), 64'd4);
      check("b.ready", 64'(b_axis_ready), 64'd1);
      tick();
      check("b.end.valid", 64'(b_gp_valid), 64'd0);

      // Reset after the beat-0 handshake discards the packet
      a_axis_valid = 1'b1; a_axis_data = 48'h9876_5432_10FE;
      tick();
      a_axis_valid = 1'b0;
      tick();
      check_a("rm.b1", 32'h0000_9876, 4'b0011, 1'b1, 8'd4, 8'd1);
      rst = 1'b1;
      #1 check("rm.ready", 64'(a_axis_ready), 64'd0);
      tick();
      check("rm.valid", 64'(a_gp_valid), 64'd0);
      check("rm.last",  64'(a_gp_last),  64'd0);
      check("rm.data",  64'(a_gp_data),  64'd0);
      check("rm.keep",  64'(a_gp_keep),  64'd0);
      check("rm.dest",  64'(a_gp_dest),  64'd0);
      check("rm.tid",   64'(a_gp_tid),   64'd0);
      rst = 1'b0;
      a_axis_valid = 1'b1; a_axis_data = 48'h0000_0000_0042;
      #1 check("rm.idle.ready", 64'(a_axis_ready), 64'd1);
      tick();
      a_axis_valid = 1'b0;
      check_a("rm.fresh.b0", 32'h0000_0042, 4'b1111, 1'b0, 8'd4, 8'd1);
      tick();
      check_a("rm.fresh.b1", 32'h0000_0000, 4'b0011, 1'b1, 8'd4, 8'd1);
      tick();
      check("rm.end.valid", 64'(a_gp_valid), 64'd0);

      // Destination and own id changed mid-packet
      a_axis_valid = 1'b1; a_axis_data = 48'hCAFE_0000_BEEF;
      tick();
      a_axis_valid = 1'b0;
      tick();
      dest_tid = 8'd7; core_tid = 32'hFFFF_FF02;
      #1;
      check_a("dc.b1", 32'h0000_CAFE, 4'b0011, 1'b1, 8'd4, 8'd1);
      tick();
      check("dc.end.valid", 64'(a_gp_valid), 64'd0);
      a_axis_valid = 1'b1; a_axis_data = 48'h0102_0304_0506;
      tick();
      a_axis_valid = 1'b0;
      check_a("dc.next.b0", 32'h0304_0506, 4'b1111, 1'b0, 8'd7, 8'h02);
      tick();
      check_a("dc.next.b1", 32'h0000_0102, 4'b0011, 1'b1, 8'd7, 8'h02);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
